hex_entry: RTL and testbench
============================

Name: hex_entry

Overview:
- User-input capture block for the lab board: the input-side counterpart of the 4-digit seven-segment output path.
- Takes a raw 4-bit nibble from switches plus raw ENTER and CLEAR buttons.
- Synchronises and debounces the buttons, then shifts nibbles into a 16-bit word, most-significant nibble entered first.
- Presents the word to the datapath with a valid/ack handshake. The same word can drive the display multiplexer as digits are typed.

Parameters:
DB_CYCLES, 1000, consecutive stable clock cycles required before a button level change is accepted (minimum 2)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
user_in  input  4  raw nibble switches (asynchronous to clk)
enter  input  1  raw ENTER button, active-high, bouncy
clear  input  1  raw CLEAR button, active-high, bouncy
ack  input  1  synchronous one-cycle consume strobe from downstream
value_out  output  16  assembled word
digit_count  output  3  digits entered so far, 0..4
valid  output  1  high while 4 digits are held and not yet acknowledged

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- reset low forces all flops to 0 immediately: sync chains, debounce counters, debounced levels, value_out=0, digit_count=0, valid=0. FSM goes to COLLECT.

Synchronisers:
- enter, clear and each user_in bit each pass through a 2-flop synchroniser. The stage-2 outputs are s_enter, s_clear and s_nib.

Debounce (one instance each for enter and clear):
- Each instance has a counter and a debounced level db.
- If s_x != db: counter increments each cycle. When the counter is at DB_CYCLES-1 and s_x still differs, db <= s_x and the counter <= 0 on that edge.
- If s_x == db: counter <= 0. Any bounce restarts the count.
- Press pulse p_x = db & ~db_d, where db_d is db delayed one cycle. p_x is exactly one cycle wide per accepted rising level. Falling levels produce no pulse.

Latency:
- Raw input rises before edge 1; s_x is high after edge 2.
- db goes high after edge 2+DB_CYCLES; p_x is high during the following cycle.
- value_out and digit_count update at edge 3+DB_CYCLES.

FSM states:
- COLLECT:
  - p_enter: if digit_count==0, value_out <= {12'h000, s_nib}; otherwise value_out <= {value_out[11:0], s_nib}.
  - digit_count increments on each p_enter. When it reaches 4, go to FULL and set valid=1 on the same edge.
  - ack in COLLECT is ignored.
- FULL:
  - valid=1 and value_out stable.
  - p_enter is ignored; no shift, no count change.
  - ack: valid <= 0, digit_count <= 0, go to COLLECT. value_out is retained, for display, until the next p_enter reloads it.

Priority and simultaneous events:
- clear beats ack, and ack beats enter.
- p_clear in any state: value_out <= 0, digit_count <= 0, valid <= 0, go to COLLECT.
- p_clear and p_enter in the same cycle: clear wins and the nibble is dropped.
- ack and p_enter in the same cycle in FULL: the ack is taken and the enter is dropped.

Other rules:
- Holding enter produces exactly one digit; a new digit needs release (db low) followed by a fresh accepted press.
- digit_count never exceeds 4; value_out has no wrap-around or overflow path.
- reset asserted mid-debounce or mid-entry discards everything. After release, the first accepted press starts a new word.
- user_in changes are not debounced. The nibble value used is s_nib in the p_enter cycle.

Test Plan:
All scenarios run with DB_CYCLES=4.
1. Reset: release reset, hold all inputs low 20 cycles -> value_out=16'h0000, digit_count=0, valid=0 throughout. Assert reset mid-count -> all outputs 0 immediately, asynchronously.
2. Four-digit entry: press nibbles 4'hA, 4'h3, 4'hF, 4'h1, each press held 10 cycles with 10 cycles released between presses.
   - Each digit_count step lands exactly 7 edges after its raw rise.
   - Final value_out=16'hA3F1, digit_count=4, valid=1 on the 4th update edge.
3. Bounce rejection: toggle enter high 3 cycles, low 1, high 2, low, repeated for 40 cycles -> no p_enter, digit_count stays 0. Then hold enter high 6 cycles -> exactly one digit accepted.
4. Full and handshake:
   - In FULL with 16'hA3F1, press enter with nibble 4'h7 -> ignored; value_out stays 16'hA3F1, digit_count=4.
   - Pulse ack for one cycle -> next edge valid=0, digit_count=0, value_out still 16'hA3F1.
   - Next press with nibble 4'h5 -> value_out=16'h0005, digit_count=1.
5. Clear priority: after 2 digits (16'h00B2), make enter and clear accepted in the same cycle -> value_out=0, digit_count=0, valid=0. Separately, clear while in FULL -> same result with no ack needed.
6. Hold behaviour: hold enter high 100 cycles -> exactly one digit. Release, then press again -> second digit accepted.

Source files
------------

// File: rtl/hex_entry.sv
`default_nettype none
// ============================================================================
//  Module   : hex_entry
//  Purpose  : Keypad-style hex word entry for the lab board. A 4-bit switch
//             nibble is captured on each debounced ENTER press and shifted
//             into a 16-bit word, most-significant nibble first. After four
//             digits the word is offered downstream with a valid/ack
//             handshake. A debounced CLEAR press discards the word at any
//             time.
//
//  Ports    : clk          system clock, all state on the rising edge
//             reset        asynchronous, active-low reset
//             user_in[3:0] raw nibble switches (asynchronous to clk)
//             enter        raw ENTER button, active-high, bouncy
//             clear        raw CLEAR button, active-high, bouncy
//             ack          one-cycle consume strobe from downstream
//             value_out    assembled 16-bit word (also usable as display data)
//             digit_count  digits entered so far, 0..4
//             valid        high while a complete word awaits ack
//
//  Revision : 1.0  initial release
// ============================================================================
module hex_entry #(
    parameter int DB_CYCLES = 1000   // stable cycles before a level is accepted (>= 2)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  user_in,
    input  logic        enter,
    input  logic        clear,
    input  logic        ack,
    output logic [15:0] value_out,
    output logic [2:0]  digit_count,
    output logic        valid
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The debounce counter only ever needs to reach DB_CYCLES-1.
    localparam int                 c_CNT_W     = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DB_CYCLES - 1);
    localparam int                 c_BTN_ENTER = 0;
    localparam int                 c_BTN_CLEAR = 1;
    localparam logic [2:0]         c_LAST_DIG  = 3'd3;   // count before the 4th digit

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers for both buttons and all nibble bits
    // ------------------------------------------------------------------------
    logic [1:0] r_btn_s1;
    logic [1:0] r_btn_s2;
    logic [3:0] r_nib_s1;
    logic [3:0] r_nib_s2;
    logic [1:0] w_btn_raw;

    assign w_btn_raw[c_BTN_ENTER] = enter;
    assign w_btn_raw[c_BTN_CLEAR] = clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_nib_s1 <= '0;
            r_nib_s2 <= '0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_nib_s1 <= user_in;
            r_nib_s2 <= r_nib_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce + rising-edge press detect, one instance per button.
    // A level change is accepted only after the synchronised input has
    // differed from the debounced level for DB_CYCLES consecutive edges;
    // any return to the current level restarts the count from zero.
    // ------------------------------------------------------------------------
    logic [1:0] w_press;

    for (genvar b = 0; b < 2; b++) begin : g_db
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_db;
        logic               r_db_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_db_d <= 1'b0;
            end else begin
                r_db_d <= r_db;
                if (r_btn_s2[b] != r_db) begin
                    if (r_cnt == c_CNT_MAX) begin
                        r_db  <= r_btn_s2[b];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // One-cycle pulse per accepted rising level; releases give nothing,
        // so a held button produces exactly one press.
        assign w_press[b] = r_db & ~r_db_d;
    end

    logic       w_p_enter;
    logic       w_p_clear;
    logic [3:0] w_s_nib;

    assign w_p_enter = w_press[c_BTN_ENTER];
    assign w_p_clear = w_press[c_BTN_CLEAR];
    assign w_s_nib   = r_nib_s2;

    // ------------------------------------------------------------------------
    // Entry state machine
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_value;
    logic [15:0] w_value_nxt;
    logic [2:0]  r_count;
    logic [2:0]  w_count_nxt;
    logic        r_valid;
    logic        w_valid_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_COLLECT;
            r_value <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Priority: clear > ack > enter. Clear is handled ahead of the state
    // case so a simultaneous enter nibble is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_count_nxt = r_count;
        w_valid_nxt = r_valid;

        if (w_p_clear) begin
            w_state_nxt = ST_COLLECT;
            w_value_nxt = '0;
            w_count_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    // ack has no meaning until a full word is held.
                    if (w_p_enter) begin
                        // The first digit reloads the word, so a value kept
                        // on the display after an ack is discarded here.
                        if (r_count == 3'd0) begin
                            w_value_nxt = {12'h000, w_s_nib};
                        end else begin
                            w_value_nxt = {r_value[11:0], w_s_nib};
                        end
                        w_count_nxt = r_count + 3'd1;
                        if (r_count == c_LAST_DIG) begin
                            w_state_nxt = ST_FULL;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Enter presses are ignored; the word is frozen until
                    // consumed. value_out is kept for display after ack.
                    if (ack) begin
                        w_state_nxt = ST_COLLECT;
                        w_count_nxt = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_COLLECT;
                end
            endcase
        end
    end

    assign value_out   = r_value;
    assign digit_count = r_count;
    assign valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_hex_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_entry
//  Purpose  : Self-checking bench for hex_entry with DB_CYCLES=4. A table of
//             press/ack/clear operations with hand-computed results drives
//             the main entry and handshake flow; bounce, hold, simultaneous
//             enter+clear and asynchronous reset are hand-written sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hex_entry;

    localparam int DB = 4;

    localparam logic [1:0] OP_PRESS = 2'd0;
    localparam logic [1:0] OP_ACK   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  nib;
        logic [15:0] exp_value;
        logic [2:0]  exp_count;
        logic        exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  user_in = 4'h0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] value_out;
    logic [2:0]  digit_count;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    // Expected state before the current operation, used for the
    // "nothing changes one edge early" latency checks.
    logic [15:0] prev_value = 16'h0;
    logic [2:0]  prev_count = 3'd0;
    logic        prev_valid = 1'b0;

    vec_t vecs[13];

    hex_entry #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .user_in     (user_in),
        .enter       (enter),
        .clear       (clear),
        .ack         (ack),
        .value_out   (value_out),
        .digit_count (digit_count),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] v, input logic [2:0] c, input logic vl);
        chk({nm, ".value"}, value_out, v);
        chk({nm, ".count"}, {13'd0, digit_count}, {13'd0, c});
        chk({nm, ".valid"}, {15'd0, valid}, {15'd0, vl});
        prev_value = v;
        prev_count = c;
        prev_valid = vl;
    endtask

    // Raw rise before edge 1; result must appear exactly at edge 3+DB.
    task automatic press_btn(input string nm, input logic is_clear, input logic [3:0] nib,
                             input logic [15:0] v, input logic [2:0] c, input logic vl);
        user_in = nib;
        if (is_clear) clear = 1'b1; else enter = 1'b1;
        repeat (DB + 2) tick();
        chk({nm, ".early_value"}, value_out, prev_value);
        chk({nm, ".early_count"}, {13'd0, digit_count}, {13'd0, prev_count});
        tick();
        chk_all(nm, v, c, vl);
        repeat (3) tick();
        enter = 1'b0;
        clear = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        vecs[0]  = '{OP_PRESS, 4'hA, 16'h000A, 3'd1, 1'b0};
        vecs[1]  = '{OP_PRESS, 4'h3, 16'h00A3, 3'd2, 1'b0};
        vecs[2]  = '{OP_PRESS, 4'hF, 16'h0A3F, 3'd3, 1'b0};
        vecs[3]  = '{OP_PRESS, 4'h1, 16'hA3F1, 3'd4, 1'b1};
        vecs[4]  = '{OP_PRESS, 4'h7, 16'hA3F1, 3'd4, 1'b1};   // ignored in FULL
        vecs[5]  = '{OP_ACK,   4'h0, 16'hA3F1, 3'd0, 1'b0};   // word kept for display
        vecs[6]  = '{OP_PRESS, 4'h5, 16'h0005, 3'd1, 1'b0};   // first digit reloads
        vecs[7]  = '{OP_CLEAR, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[8]  = '{OP_PRESS, 4'h1, 16'h0001, 3'd1, 1'b0};
        vecs[9]  = '{OP_PRESS, 4'h2, 16'h0012, 3'd2, 1'b0};
        vecs[10] = '{OP_PRESS, 4'h3, 16'h0123, 3'd3, 1'b0};
        vecs[11] = '{OP_PRESS, 4'h4, 16'h1234, 3'd4, 1'b1};
        vecs[12] = '{OP_CLEAR, 4'h0, 16'h0000, 3'd0, 1'b0};   // clear from FULL, no ack

        // ---------------- reset ----------------
        #2 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all($sformatf("reset_idle%0d", i), 16'h0, 3'd0, 1'b0);
        end

        // ---------------- table-driven entry / handshake / clear ----------------
        for (int i = 0; i < 13; i++) begin
            case (vecs[i].op)
                OP_PRESS: press_btn($sformatf("vec%0d_press", i), 1'b0, vecs[i].nib,
                                    vecs[i].exp_value, vecs[i].exp_count, vecs[i].exp_valid);
                OP_CLEAR: press_btn($sformatf("vec%0d_clear", i), 1'b1, vecs[i].nib,
                                    vecs[i].exp_value, vecs[i].exp_count, vecs[i].exp_valid);
                default: begin
                    chk($sformatf("vec%0d_pre_ack_valid", i), {15'd0, valid}, 16'd1);
                    ack = 1'b1;
                    tick();
                    ack = 1'b0;
                    chk_all($sformatf("vec%0d_ack", i), vecs[i].exp_value,
                            vecs[i].exp_count, vecs[i].exp_valid);
                    repeat (2) tick();
                end
            endcase
        end

        // ---------------- enter and clear accepted together ----------------
        press_btn("sim_d1", 1'b0, 4'hB, 16'h000B, 3'd1, 1'b0);
        press_btn("sim_d2", 1'b0, 4'h2, 16'h00B2, 3'd2, 1'b0);
        user_in = 4'h9;
        enter   = 1'b1;
        clear   = 1'b1;
        repeat (DB + 3) tick();
        chk_all("sim_clear_wins", 16'h0, 3'd0, 1'b0);
        repeat (3) tick();
        enter = 1'b0;
        clear = 1'b0;
        repeat (10) tick();
        chk_all("sim_after", 16'h0, 3'd0, 1'b0);

        // ---------------- bounce rejection ----------------
        user_in = 4'hE;
        for (int r = 0; r < 6; r++) begin
            enter = 1'b1; repeat (3) tick();
            enter = 1'b0; tick();
            enter = 1'b1; repeat (2) tick();
            enter = 1'b0; tick();
        end
        repeat (6) tick();
        chk_all("bounce_reject", 16'h0, 3'd0, 1'b0);
        user_in = 4'h9;
        enter   = 1'b1;
        repeat (6) tick();
        enter = 1'b0;
        repeat (10) tick();
        chk_all("bounce_hold6", 16'h0009, 3'd1, 1'b0);

        // ---------------- long hold gives one digit ----------------
        user_in = 4'h6;
        enter   = 1'b1;
        repeat (100) tick();
        chk_all("hold100", 16'h0096, 3'd2, 1'b0);
        enter = 1'b0;
        repeat (10) tick();
        chk_all("hold_release", 16'h0096, 3'd2, 1'b0);
        press_btn("hold_next", 1'b0, 4'h8, 16'h0968, 3'd3, 1'b0);

        // ---------------- asynchronous reset mid-entry ----------------
        user_in = 4'h3;
        enter   = 1'b1;
        repeat (3) tick();           // mid-debounce as well
        #2 reset = 1'b0;             // away from any clock edge
        #1;
        chk_all("async_reset", 16'h0, 3'd0, 1'b0);
        enter = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk_all("post_reset", 16'h0, 3'd0, 1'b0);
        press_btn("post_reset_press", 1'b0, 4'h4, 16'h0004, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
